// File: rtl/dmem_pkg.sv
// Shared types and helpers for the subword data memory and its store-trace FIFO.
package dmem_pkg;

  typedef enum logic [1:0] {
    SZ_BYTE = 2'b00,
    SZ_HALF = 2'b01,
    SZ_WORD = 2'b10
  } size_t;

  typedef struct packed {
    logic [31:0] addr;
    logic [31:0] data;
    logic [1:0]  size;
  } trace_entry_t;

  // Byte lanes touched by an access; the reserved size encoding behaves as a word.
  function automatic logic [3:0] laneMask(input logic [1:0] size, input logic [1:0] lane);
    case (size)
      SZ_BYTE: laneMask = 4'b0001 << lane;
      SZ_HALF: laneMask = lane[1] ? 4'b1100 : 4'b0011;
      default: laneMask = 4'b1111;
    endcase
  endfunction

endpackage

// File: rtl/dmem_trace_fifo.sv
// Circular store-trace FIFO; a push into a full FIFO is dropped and latches a sticky overflow flag.
module dmem_trace_fifo
  import dmem_pkg::*;
#(
  parameter int TRACE_DEPTH = 8
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         i_push,
  input  trace_entry_t i_entry,
  input  logic         i_pop,
  output trace_entry_t o_head,
  output logic         o_empty,
  output logic         o_full,
  output logic         o_overflow
);

  localparam int PW = $clog2(TRACE_DEPTH);

  trace_entry_t   r_buf [TRACE_DEPTH];
  logic [PW-1:0]  r_wptr;
  logic [PW-1:0]  r_rptr;
  logic [PW:0]    r_count;
  logic           r_overflow;
  logic           w_popOk;
  logic           w_pushOk;

  assign o_empty    = (r_count == '0);
  assign o_full     = (r_count == (PW+1)'(TRACE_DEPTH));
  assign o_overflow = r_overflow;
  assign o_head     = o_empty ? '0 : r_buf[r_rptr];

  // A pop frees a slot in the same cycle, so push is still accepted when full.
  assign w_popOk  = i_pop & ~o_empty;
  assign w_pushOk = i_push & (~o_full | w_popOk);

  always_ff @(posedge clk) begin
    if (reset) begin
      r_wptr     <= '0;
      r_rptr     <= '0;
      r_count    <= '0;
      r_overflow <= 1'b0;
    end else begin
      if (w_pushOk) r_wptr <= r_wptr + 1'b1;
      if (w_popOk) r_rptr <= r_rptr + 1'b1;
      if (i_push & ~w_pushOk) r_overflow <= 1'b1;
      r_count <= r_count + (PW+1)'(w_pushOk) - (PW+1)'(w_popOk);
    end
  end

  always_ff @(posedge clk) begin
    if (!reset && w_pushOk) r_buf[r_wptr] <= i_entry;
  end

endmodule

// File: rtl/dmem_subword.sv
// Byte-addressed data memory with sub-word loads/stores; the store-trace FIFO
// exists only when DMEM_STORE_TRACE_EN is defined, otherwise trace outputs are 0.
module dmem_subword
  import dmem_pkg::*;
#(
  parameter int DEPTH       = 64,
  parameter int TRACE_DEPTH = 8
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        memwrite,
  input  logic [1:0]  size,
  input  logic        unsigned_ld,
  input  logic [31:0] dataadr,
  input  logic [31:0] writedata,
  output logic [31:0] readdata,
  output logic        misalign,
  output logic        trace_valid,
  input  logic        trace_ready,
  output logic [31:0] trace_addr,
  output logic [31:0] trace_data,
  output logic [1:0]  trace_size,
  output logic        trace_overflow
);

  localparam int AW = $clog2(DEPTH);

  logic [31:0]   r_mem [DEPTH];
  logic [AW-1:0] w_idx;
  logic [1:0]    w_lane;
  logic [31:0]   w_word;
  logic [31:0]   w_shifted;
  logic [31:0]   w_wshift;
  logic [31:0]   w_bitMask;
  logic [31:0]   w_merged;
  logic [3:0]    w_mask;
  logic          w_commit;

  assign w_idx     = dataadr[2 +: AW];
  assign w_lane    = dataadr[1:0];
  assign w_word    = r_mem[w_idx];
  assign w_shifted = w_word >> {w_lane, 3'b000};
  assign w_wshift  = writedata << {w_lane, 3'b000};
  assign w_mask    = laneMask(size, w_lane);
  assign w_merged  = (w_word & ~w_bitMask) | (w_wshift & w_bitMask);
  assign w_commit  = memwrite & ~misalign & ~reset;

  always_comb begin
    w_bitMask = '0;
    for (int i = 0; i < 4; i++) w_bitMask[8*i +: 8] = {8{w_mask[i]}};
  end

  always_comb begin
    case (size)
      SZ_BYTE: misalign = 1'b0;
      SZ_HALF: misalign = w_lane[0];
      default: misalign = (w_lane != 2'b00);
    endcase
  end

  // Lane data is already shifted down to bit 0; only extension remains.
  always_comb begin
    readdata = '0;
    if (!misalign) begin
      case (size)
        SZ_BYTE: readdata = unsigned_ld ? {24'b0, w_shifted[7:0]}
                                        : {{24{w_shifted[7]}}, w_shifted[7:0]};
        SZ_HALF: readdata = unsigned_ld ? {16'b0, w_shifted[15:0]}
                                        : {{16{w_shifted[15]}}, w_shifted[15:0]};
        default: readdata = w_word;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
    end else if (w_commit) begin
      r_mem[w_idx] <= w_merged;
    end
  end

`ifdef DMEM_STORE_TRACE_EN
  trace_entry_t w_entry;
  trace_entry_t w_head;
  logic         w_empty;
  logic         w_unusedFull;

  assign w_entry = '{addr: dataadr, data: w_merged, size: size};

  dmem_trace_fifo #(
    .TRACE_DEPTH(TRACE_DEPTH)
  ) u_traceFifo (
    .clk       (clk),
    .reset     (reset),
    .i_push    (w_commit),
    .i_entry   (w_entry),
    .i_pop     (trace_ready),
    .o_head    (w_head),
    .o_empty   (w_empty),
    .o_full    (w_unusedFull),
    .o_overflow(trace_overflow)
  );

  assign trace_valid = ~w_empty;
  assign trace_addr  = w_head.addr;
  assign trace_data  = w_head.data;
  assign trace_size  = w_head.size;
`else
  logic w_unused;

  assign w_unused       = ^{trace_ready, dataadr};
  assign trace_valid    = 1'b0;
  assign trace_addr     = '0;
  assign trace_data     = '0;
  assign trace_size     = '0;
  assign trace_overflow = 1'b0;
`endif

endmodule
